sl811_bus_ctrl: RTL and testbench
=================================

# sl811_bus_ctrl

Bus sequencer between internal requesters and the SL811 USB host controller's parallel port. Each request is a two-phase SL811 access: an address write (a0=0), then a data read or write (a0=1), with programmable strobe and recovery widths. Two requester ports share the chip under round-robin arbitration. The block also drives the SL811 reset and master/slave pins and conditions intrq for the CPU side.

## Interface
- STB_CYC, 3: strobe-low width in fclk cycles; legal range 1..15.
- GAP_CYC, 2: recovery width (all strobes high) after each strobe; legal range 1..15.

Ports: name, direction, width, meaning.
- fclk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request; held high until the matching ack.
- rnw0 / rnw1  in  1  1 = read, 0 = write.
- addr0 / addr1  in  8  SL811 register address.
- wdat0 / wdat1  in  8  write data.
- ack0 / ack1  out  1  one-cycle pulse: request latched, inputs may change.
- done0 / done1  out  1  one-cycle pulse: access complete; rdata valid if read.
- rdata  out  8  last read data; held until the next read completes.
- ctl_rst  in  1  software reset level for the SL811.
- ctl_ms  in  1  value driven onto the SL811 ms pin.
- int_clr  in  1  clears int_pend (used only with the macro).
- int_pend  out  1  interrupt status to the CPU.
- sl_a0, sl_cs_n, sl_rd_n, sl_wr_n  out  1  SL811 bus controls.
- sl_d_out  out  8  data to the SL811.
- sl_d_oe  out  1  drive enable for sl_d_out.
- sl_d_in  in  8  data from the SL811.
- sl_rst_n  out  1  SL811 reset.
- sl_ms  out  1  SL811 mode select.
- sl_intrq  in  1  SL811 interrupt; asynchronous.

## Operation
States: IDLE, ASTB, AGAP, DSTB, DGAP. A 4-bit counter times each state.
- **IDLE.** If ctl_rst=0 and any req is high, grant one requester.
  - Latch its rnw, addr and wdat; pulse its ack; go to ASTB.
  - If ctl_rst=1, requests are held pending.
- **ASTB** (STB_CYC cycles): sl_a0=0, sl_cs_n=0, sl_wr_n=0, sl_d_out=addr, sl_d_oe=1.
- **AGAP** (GAP_CYC cycles): cs_n, rd_n and wr_n high; a0 holds its value.
  - sl_d_oe stays 1 in the first AGAP cycle only (hold time).
- **DSTB** (STB_CYC cycles): sl_a0=1, sl_cs_n=0.
  - Write: sl_wr_n=0, sl_d_out=wdat, sl_d_oe=1.
  - Read: sl_rd_n=0, sl_d_oe=0. sl_d_in is registered into rdata on the edge that ends the last DSTB cycle.
- **DGAP** (GAP_CYC cycles): same rules as AGAP. Then go to IDLE and pulse the owner's done.
- **Arbitration.** Round-robin on a last-grant flag.
  - After reset, port 0 wins a tie.
  - With both requesting continuously, grants alternate 0,1,0,1.
  - A lone requester is granted every time.
- **Control pins.** sl_rst_n is registered ~(rst|ctl_rst). sl_ms is registered ctl_ms.
- **ctl_rst during an access.** An access already in flight completes normally.
- **rst.** Aborts any state immediately; all outputs take their reset values on the next cycle.
- **Protocol errors.** A req dropped before its ack is ignored. rd_n and wr_n are never low together.

## Timing
- Reset values: sl_cs_n=1, sl_rd_n=1, sl_wr_n=1, sl_a0=0, sl_d_out=0, sl_d_oe=0, sl_rst_n=0, sl_ms=0, ack*=0, done*=0, rdata=0, int_pend=0, state=IDLE, last-grant=1.
- Request sampled high at edge E0 → ack high during cycle E0..E1; sl_cs_n low from E0.
- done rises at E0+2·(STB_CYC+GAP_CYC) and lasts one cycle. With defaults this is E0+10.
- The IDLE cycle carrying done may sample the next request.
  - Back-to-back accesses are spaced 2·(STB_CYC+GAP_CYC)+1 cycles: 11 with defaults.
  - The minimum strobe-high time between accesses is GAP_CYC+1.
- sl_rst_n and sl_ms change one cycle after ctl_rst / ctl_ms change.

## Configuration
Macro: SL811_INT_LATCH_EN. In both modes, sl_intrq passes through a 2-flop synchronizer first.
- **Defined:** a rising edge of the synchronized intrq sets a sticky int_pend.
  - int_clr clears int_pend one cycle later.
  - If an edge and int_clr occur in the same cycle, set wins.
- **Undefined:** int_pend equals the synchronized intrq level (2-cycle latency); int_clr is ignored.

## Test plan
1. Port 0 write, addr=0x05, wdat=0xA7 → a0=0 strobe drives 0x05 for 3 cycles, a0=1 wr strobe drives 0xA7 for 3 cycles; ack0 at +0, done0 at +10.
2. Port 1 read, addr=0x0D, SL811 model returns 0x3C → rd_n low 3 cycles with d_oe=0; rdata=0x3C when done1 pulses at +10.
3. req0 and req1 both high from reset for 4 accesses → grants in order 0,1,0,1; no strobe overlap; done spacing 11 cycles.
4. ctl_rst raised during DSTB of a write → write completes and done0 pulses; sl_rst_n=0 one cycle after ctl_rst; pending req1 gets no ack until ctl_rst=0.
5. rst pulsed during AGAP → next cycle cs_n=1, d_oe=0, state IDLE; no done pulse.
6. sl_intrq pulse of 5 cycles, then int_clr → with the macro, int_pend goes high and stays high until the cycle after int_clr; without it, int_pend follows intrq delayed 2 cycles.

Source files
------------

// File: rtl/sl811_bus_ctrl.sv
// Two-port round-robin sequencer for the SL811 parallel bus: address write, then data read/write.
// Define SL811_INT_LATCH_EN to make int_pend a sticky, int_clr-cleared edge latch instead of a level.
module sl811_bus_ctrl #(
  parameter int unsigned STB_CYC = 3,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       rnw0,
  input  logic       rnw1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdat0,
  input  logic [7:0] wdat1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  input  logic       ctl_rst,
  input  logic       ctl_ms,
  input  logic       int_clr,
  output logic       int_pend,
  output logic       sl_a0,
  output logic       sl_cs_n,
  output logic       sl_rd_n,
  output logic       sl_wr_n,
  output logic [7:0] sl_d_out,
  output logic       sl_d_oe,
  input  logic [7:0] sl_d_in,
  output logic       sl_rst_n,
  output logic       sl_ms,
  input  logic       sl_intrq
);

  typedef enum logic [2:0] {IDLE, ASTB, AGAP, DSTB, DGAP} state_e;

  localparam logic [3:0] STB_LAST = 4'(STB_CYC - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        sel1;
  logic        cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic        a0_q, a0_d, oe_q, oe_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rst_n_q, ms_q;
  logic [1:0]  sync_q;

  // Port 1 wins when it is alone, or on a tie when port 0 had the last grant.
  assign sel1 = req1 && (!req0 || !last_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    last_d  = last_q;
    owner_d = owner_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (!ctl_rst && (req0 || req1)) begin
          owner_d = sel1;
          last_d  = sel1;
          rnw_d   = sel1 ? rnw1  : rnw0;
          addr_d  = sel1 ? addr1 : addr0;
          wdat_d  = sel1 ? wdat1 : wdat0;
          ack0_d  = !sel1;
          ack1_d  = sel1;
          state_d = ASTB;
        end
      end
      ASTB: if (cnt_q == STB_LAST) begin state_d = AGAP; cnt_d = 4'd0; end
      AGAP: if (cnt_q == GAP_LAST) begin state_d = DSTB; cnt_d = 4'd0; end
      DSTB: if (cnt_q == STB_LAST) begin state_d = DGAP; cnt_d = 4'd0; end
      DGAP: if (cnt_q == GAP_LAST) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        done0_d = !owner_q;
        done1_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus pins are registered from the next state, so they change on the same edge as the FSM.
  always_comb begin
    cs_n_d  = !(state_d == ASTB || state_d == DSTB);
    rd_n_d  = !(state_d == DSTB && rnw_d);
    wr_n_d  = !(state_d == ASTB || (state_d == DSTB && !rnw_d));
    a0_d    = a0_q;
    dout_d  = dout_q;
    oe_d    = 1'b0;
    rdata_d = rdata_q;
    if (state_d == ASTB) begin
      a0_d   = 1'b0;
      dout_d = addr_d;
      oe_d   = 1'b1;
    end else if (state_d == DSTB) begin
      a0_d = 1'b1;
      oe_d = !rnw_d;
      if (!rnw_d) dout_d = wdat_d;
    end else if ((state_d == AGAP || state_d == DGAP) &&
                 (state_q == ASTB || state_q == DSTB)) begin
      oe_d = oe_q;  // first recovery cycle keeps the data driven for hold time
    end
    if (state_q == DSTB && cnt_q == STB_LAST && rnw_q) rdata_d = sl_d_in;
  end

  always_ff @(posedge fclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= 8'h00;
      wdat_q  <= 8'h00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      a0_q    <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      rdata_q <= 8'h00;
      rst_n_q <= 1'b0;
      ms_q    <= 1'b0;
      sync_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      a0_q    <= a0_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      rst_n_q <= !ctl_rst;
      ms_q    <= ctl_ms;
      sync_q  <= {sync_q[0], sl_intrq};
    end
  end

`ifdef SL811_INT_LATCH_EN
  logic int_prev_q, int_pend_q;

  // A new edge takes priority over a simultaneous clear so no interrupt is lost.
  always_ff @(posedge fclk) begin
    if (rst) begin
      int_prev_q <= 1'b0;
      int_pend_q <= 1'b0;
    end else begin
      int_prev_q <= sync_q[1];
      if (sync_q[1] && !int_prev_q) int_pend_q <= 1'b1;
      else if (int_clr)              int_pend_q <= 1'b0;
    end
  end

  assign int_pend = int_pend_q;
`else
  logic unused_int_clr;
  assign unused_int_clr = int_clr;
  assign int_pend       = sync_q[1];
`endif

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata    = rdata_q;
  assign sl_a0    = a0_q;
  assign sl_cs_n  = cs_n_q;
  assign sl_rd_n  = rd_n_q;
  assign sl_wr_n  = wr_n_q;
  assign sl_d_out = dout_q;
  assign sl_d_oe  = oe_q;
  assign sl_rst_n = rst_n_q;
  assign sl_ms    = ms_q;

endmodule

// File: tb/tb_sl811_bus_ctrl.sv
// Directed bench for sl811_bus_ctrl with default STB_CYC=3, GAP_CYC=2; follows SL811_INT_LATCH_EN if defined.
module tb_sl811_bus_ctrl;

  logic       fclk = 1'b0;
  logic       rst, req0, req1, rnw0, rnw1, ctl_rst, ctl_ms, int_clr, sl_intrq;
  logic [7:0] addr0, addr1, wdat0, wdat1, read_val;
  logic       ack0, ack1, done0, done1, int_pend;
  logic       sl_a0, sl_cs_n, sl_rd_n, sl_wr_n, sl_d_oe, sl_rst_n, sl_ms;
  logic [7:0] rdata, sl_d_out, sl_d_in;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 fclk = ~fclk;

  // SL811 model: drives read_val only while a read strobe is active.
  assign sl_d_in = (!sl_cs_n && !sl_rd_n) ? read_val : 8'h00;

  sl811_bus_ctrl dut (
    .fclk(fclk), .rst(rst),
    .req0(req0), .req1(req1), .rnw0(rnw0), .rnw1(rnw1),
    .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .rdata(rdata),
    .ctl_rst(ctl_rst), .ctl_ms(ctl_ms), .int_clr(int_clr), .int_pend(int_pend),
    .sl_a0(sl_a0), .sl_cs_n(sl_cs_n), .sl_rd_n(sl_rd_n), .sl_wr_n(sl_wr_n),
    .sl_d_out(sl_d_out), .sl_d_oe(sl_d_oe), .sl_d_in(sl_d_in),
    .sl_rst_n(sl_rst_n), .sl_ms(sl_ms), .sl_intrq(sl_intrq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge fclk);
    #1;
  endtask

  // Expected pins k cycles after the grant edge for one access.
  task automatic check_phase(input int k, input bit port, input bit rnw,
                             input logic [7:0] addr, input logic [7:0] wdat,
                             input logic [7:0] rval);
    logic astb, dstb, cs, rd, wr, a0, oe;
    logic [3:0] hs;
    astb = (k <= 2);
    dstb = (k >= 5 && k <= 7);
    cs   = !(astb || dstb);
    rd   = !(dstb && rnw);
    wr   = !(astb || (dstb && !rnw));
    a0   = (k >= 5);
    oe   = (k <= 3) || (!rnw && k >= 5 && k <= 8);
    hs   = {k == 0 && !port, k == 0 && port, k == 10 && !port, k == 10 && port};
    check($sformatf("bus_k%0d", k), 32'({sl_cs_n, sl_rd_n, sl_wr_n, sl_a0, sl_d_oe}),
          32'({cs, rd, wr, a0, oe}));
    check($sformatf("hs_k%0d", k), 32'({ack0, ack1, done0, done1}), 32'(hs));
    if (oe) check($sformatf("dout_k%0d", k), 32'(sl_d_out), 32'((k <= 3) ? addr : wdat));
    if (rnw && k == 10) check("rdata", 32'(rdata), 32'(rval));
  endtask

  task automatic wait_ack(output int port, output int n);
    port = -1;
    n    = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      n++;
      if (ack0 || ack1) begin
        port = ack1 ? 1 : 0;
        break;
      end
    end
    check("ack_seen", 32'(port >= 0), 32'(1));
  endtask

  task automatic do_access(input bit port, input bit rnw, input logic [7:0] addr,
                           input logic [7:0] wdat, input logic [7:0] rval);
    int p, n;
    read_val = rval;
    if (port) begin req1 = 1'b1; rnw1 = rnw; addr1 = addr; wdat1 = wdat; end
    else      begin req0 = 1'b1; rnw0 = rnw; addr0 = addr; wdat0 = wdat; end
    wait_ack(p, n);
    req0 = 1'b0;
    req1 = 1'b0;
    check("grant_port", 32'(p), 32'(port));
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick;
      check_phase(k, port, rnw, addr, wdat, rval);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, n;
    logic saw_done, exp_int;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rnw0 = 1'b0; rnw1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdat0 = 8'h00; wdat1 = 8'h00; read_val = 8'h00;
    ctl_rst = 1'b0; ctl_ms = 1'b0; int_clr = 1'b0; sl_intrq = 1'b0;
    tick;
    tick;

    // Reset values
    check("rst_bus", 32'({sl_cs_n, sl_rd_n, sl_wr_n, sl_a0, sl_d_oe}), 32'(5'b11100));
    check("rst_dout", 32'(sl_d_out), 32'(0));
    check("rst_pins", 32'({sl_rst_n, sl_ms}), 32'(0));
    check("rst_hs", 32'({ack0, ack1, done0, done1}), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_int", 32'(int_pend), 32'(0));
    rst = 1'b0;
    tick;
    check("sl_rst_n_release", 32'(sl_rst_n), 32'(1));

    check("ms_before", 32'(sl_ms), 32'(0));
    ctl_ms = 1'b1;
    tick;
    check("ms_set", 32'(sl_ms), 32'(1));
    ctl_ms = 1'b0;
    tick;
    check("ms_clr", 32'(sl_ms), 32'(0));

    // Single write on port 0, single read on port 1
    do_access(1'b0, 1'b0, 8'h05, 8'hA7, 8'h00);
    do_access(1'b1, 1'b1, 8'h0D, 8'h00, 8'h3C);

    // Both ports requesting continuously from reset: 0,1,0,1 with 11-cycle spacing
    rst = 1'b1;
    tick;
    addr0 = 8'h10; wdat0 = 8'h5A; rnw0 = 1'b0;
    addr1 = 8'h21; wdat1 = 8'h00; rnw1 = 1'b1; read_val = 8'hC3;
    req0 = 1'b1; req1 = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(p, n);
      check($sformatf("arb_port_%0d", i), 32'(p), 32'(i % 2));
      if (i > 0) check($sformatf("arb_spacing_%0d", i), 32'(n), 32'(1));
      for (int k = 0; k <= 10; k++) begin
        if (k > 0) tick;
        if (i % 2 == 0) check_phase(k, 1'b0, 1'b0, 8'h10, 8'h5A, 8'h00);
        else            check_phase(k, 1'b1, 1'b1, 8'h21, 8'h00, 8'hC3);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    check("arb_quiet", 32'({ack0, ack1}), 32'(0));

    // ctl_rst raised during the data strobe of a write
    req0 = 1'b1; rnw0 = 1'b0; addr0 = 8'h03; wdat0 = 8'h5E;
    wait_ack(p, n);
    req0 = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick;
      check_phase(k, 1'b0, 1'b0, 8'h03, 8'h5E, 8'h00);
      if (k == 5) begin
        check("ctl_rst_before", 32'(sl_rst_n), 32'(1));
        ctl_rst = 1'b1;
        req1 = 1'b1; rnw1 = 1'b0; addr1 = 8'h22; wdat1 = 8'h99;
      end
      if (k == 6) check("ctl_rst_after", 32'(sl_rst_n), 32'(0));
    end
    for (int j = 0; j < 4; j++) begin
      tick;
      check($sformatf("held_ack1_%0d", j), 32'(ack1), 32'(0));
    end
    ctl_rst = 1'b0;
    tick;
    check("held_grant", 32'(ack1), 32'(1));
    check("ctl_rst_release", 32'(sl_rst_n), 32'(1));
    req1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      check_phase(k, 1'b1, 1'b0, 8'h22, 8'h99, 8'h00);
    end

    // rst during the address recovery gap aborts the access
    req0 = 1'b1; rnw0 = 1'b0; addr0 = 8'h44; wdat0 = 8'h11;
    wait_ack(p, n);
    req0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick;
      check_phase(k, 1'b0, 1'b0, 8'h44, 8'h11, 8'h00);
    end
    rst = 1'b1;
    tick;
    check("abort_bus", 32'({sl_cs_n, sl_rd_n, sl_wr_n, sl_a0, sl_d_oe}), 32'(5'b11100));
    check("abort_hs", 32'({ack0, ack1, done0, done1}), 32'(0));
    check("abort_rst_n", 32'(sl_rst_n), 32'(0));
    rst = 1'b0;
    saw_done = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick;
      if (done0 || done1) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'(0));
    check("abort_idle_cs", 32'(sl_cs_n), 32'(1));

    // sl_intrq pulse of 5 cycles, then int_clr
    for (int k = 0; k < 12; k++) begin
      if (k == 0)  sl_intrq = 1'b1;
      if (k == 5)  sl_intrq = 1'b0;
      if (k == 9)  int_clr  = 1'b1;
      if (k == 10) int_clr  = 1'b0;
`ifdef SL811_INT_LATCH_EN
      exp_int = (k >= 3 && k <= 9);
`else
      exp_int = (k >= 2 && k <= 6);
`endif
      check($sformatf("int_pend_%0d", k), 32'(int_pend), 32'(exp_int));
      tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
